// File: rtl/rgb_layer_compositor.sv
// rgb_layer_compositor: merges the player, header, bullet and enemy0 sprite layers
// into one VGA RGB value using fixed priority instead of a bitwise OR.
//   - Two-stage pixel pipeline that advances only on pix_en.
//   - Frame-counted flash FSM (IDLE / FLASH_ON / FLASH_OFF) that blinks enemy0.
//   - Optional per-frame bullet/enemy overlap flag, built only when the macro
//     RGB_COLLISION_EN is defined; otherwise collision is tied low.
// Handshake: there is no valid/ready pair. pix_en is a one-cycle qualifier.
// A layer sample presented on pix_en tick k appears on content after tick k+1.
module rgb_layer_compositor #(
  parameter logic [5:0] BG_COLOR     = 6'b000000,
  parameter logic [5:0] FLASH_COLOR  = 6'b111111,
  parameter logic [7:0] FLASH_FRAMES = 8'd8,
  parameter logic [3:0] BLINK_FRAMES = 4'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       video_on,
  input  logic       vsync_start,
  input  logic [5:0] player,
  input  logic [5:0] header,
  input  logic [5:0] bullet,
  input  logic [5:0] enemy0,
  input  logic       hit_pulse,
  output logic [5:0] content,
  output logic       flashing,
  output logic       collision
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_e;

  flash_state_e state_q, state_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;
  logic [3:0]   blink_cnt_q, blink_cnt_d;
  logic         flashing_q;

  logic [5:0]   s1_player_q, s1_header_q, s1_bullet_q, s1_enemy_q;
  logic         s1_video_q;
  logic [5:0]   content_q, content_d;

  // Counters saturate at zero rather than wrapping.
  logic [7:0]   frame_dec;
  logic [3:0]   blink_dec;
  assign frame_dec = (frame_cnt_q != 8'd0) ? frame_cnt_q - 8'd1 : 8'd0;
  assign blink_dec = (blink_cnt_q != 4'd0) ? blink_cnt_q - 4'd1 : 4'd0;

  // Stage 1: capture the raw layers and the display-enable flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_player_q <= '0;
      s1_header_q <= '0;
      s1_bullet_q <= '0;
      s1_enemy_q  <= '0;
      s1_video_q  <= 1'b0;
    end else if (pix_en) begin
      s1_player_q <= player;
      s1_header_q <= header;
      s1_bullet_q <= bullet;
      s1_enemy_q  <= enemy0;
      s1_video_q  <= video_on;
    end
  end

  // Priority select: header > player > bullet > enemy0 > background; enemy0 is
  // replaced by the flash colour while the FSM is in its on phase.
  always_comb begin
    content_d = BG_COLOR;
    if (!s1_video_q) begin
      content_d = 6'd0;
    end else if (s1_header_q != 6'd0) begin
      content_d = s1_header_q;
    end else if (s1_player_q != 6'd0) begin
      content_d = s1_player_q;
    end else if (s1_bullet_q != 6'd0) begin
      content_d = s1_bullet_q;
    end else if (s1_enemy_q != 6'd0) begin
      content_d = (state_q == FLASH_ON) ? FLASH_COLOR : s1_enemy_q;
    end
  end

  // Stage 2: register the composited pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      content_q <= '0;
    end else if (pix_en) begin
      content_q <= content_d;
    end
  end

  // Flash FSM next state. A hit always reloads both counters and wins over a
  // coincident vsync_start; reaching frame 0 wins over a blink toggle.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    case (state_q)
      IDLE: begin
        if (hit_pulse) begin
          state_d     = FLASH_ON;
          frame_cnt_d = FLASH_FRAMES;
          blink_cnt_d = BLINK_FRAMES;
        end
      end
      FLASH_ON, FLASH_OFF: begin
        if (hit_pulse) begin
          state_d     = FLASH_ON;
          frame_cnt_d = FLASH_FRAMES;
          blink_cnt_d = BLINK_FRAMES;
        end else if (vsync_start) begin
          if (frame_dec == 8'd0) begin
            state_d     = IDLE;
            frame_cnt_d = 8'd0;
            blink_cnt_d = 4'd0;
          end else if (blink_dec == 4'd0) begin
            state_d     = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
            frame_cnt_d = frame_dec;
            blink_cnt_d = BLINK_FRAMES;
          end else begin
            frame_cnt_d = frame_dec;
            blink_cnt_d = blink_dec;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        frame_cnt_d = 8'd0;
        blink_cnt_d = 4'd0;
      end
    endcase
  end

  // Flash FSM state, counters and the registered flashing flag; runs on every clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 4'd0;
      flashing_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      flashing_q  <= (state_d != IDLE);
    end
  end

`ifdef RGB_COLLISION_EN
  logic collision_q;

  // Sticky overlap flag: set by a visible bullet/enemy overlap in stage 1,
  // cleared at frame start; the clear wins if both happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
    end else if (vsync_start) begin
      collision_q <= 1'b0;
    end else if (pix_en && s1_video_q && (s1_bullet_q != 6'd0) && (s1_enemy_q != 6'd0)) begin
      collision_q <= 1'b1;
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

  assign content  = content_q;
  assign flashing = flashing_q;

endmodule

// File: tb/tb_rgb_layer_compositor.sv
// Bench for rgb_layer_compositor: directed pixels with hand-computed colours are
// pushed into an expected queue; a monitor pops and compares each time a tagged
// pixel reaches content. Flag checks (flashing, collision, hold, reset) are direct.
module tb_rgb_layer_compositor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       video_on = 1'b0;
  logic       vsync_start = 1'b0;
  logic       hit_pulse = 1'b0;
  logic [5:0] player = '0;
  logic [5:0] header = '0;
  logic [5:0] bullet = '0;
  logic [5:0] enemy0 = '0;
  logic [5:0] content;
  logic       flashing;
  logic       collision;

  logic       drv_chk = 1'b0;
  logic       v1 = 1'b0;
  logic       v2 = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] exp_q[$];
  int         total = 0;
  int         bad = 0;

`ifdef RGB_COLLISION_EN
  localparam int COLL_SET = 1;
`else
  localparam int COLL_SET = 0;
`endif

  // Enemy colour seen in frames 1..8 after a hit with default parameters.
  logic [5:0] flash_tbl [8] = '{6'h3F, 6'h3F, 6'h03, 6'h03, 6'h3F, 6'h3F, 6'h03, 6'h03};

  rgb_layer_compositor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .video_on   (video_on),
    .vsync_start(vsync_start),
    .player     (player),
    .header     (header),
    .bullet     (bullet),
    .enemy0     (enemy0),
    .hit_pulse  (hit_pulse),
    .content    (content),
    .flashing   (flashing),
    .collision  (collision)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One pixel: inputs settle for 3 clocks, then a single pix_en clock.
  task automatic send_px(input logic vid, input logic [5:0] h, input logic [5:0] p,
                         input logic [5:0] b, input logic [5:0] e,
                         input logic chk, input logic [5:0] exp);
    video_on = vid; header = h; player = p; bullet = b; enemy0 = e;
    drv_chk = chk; pix_en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    if (chk) exp_q.push_back(exp);
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    drv_chk = 1'b0;
  endtask

  task automatic idle_px();
    send_px(1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 6'h00);
  endtask

  task automatic pulse_vsync();
    vsync_start = 1'b1;
    @(posedge clk); #1;
    vsync_start = 1'b0;
  endtask

  task automatic hit();
    hit_pulse = 1'b1;
    @(posedge clk); #1;
    hit_pulse = 1'b0;
  endtask

  // Track which tagged pixel occupies each pipeline stage.
  always @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; tick <= 1'b0;
    end else begin
      tick <= pix_en;
      if (pix_en) begin
        v1 <= drv_chk;
        v2 <= v1;
      end
    end
  end

  // Scoreboard monitor: compare on the falling edge after a stage-2 update.
  always @(negedge clk) begin
    if (tick && v2) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL content_pop: got %0h expected nothing (queue empty)", content);
      end else begin
        check("content", int'(content), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_content", int'(content), 0);
    check("rst_flashing", int'(flashing), 0);
    check("rst_collision", int'(collision), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Priority
    send_px(1'b1, 6'h00, 6'h30, 6'h0C, 6'h03, 1'b1, 6'h30); idle_px();
    send_px(1'b1, 6'h00, 6'h00, 6'h0C, 6'h03, 1'b1, 6'h0C); idle_px();
    send_px(1'b1, 6'h3C, 6'h30, 6'h0C, 6'h03, 1'b1, 6'h3C); idle_px();
    send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h00, 1'b1, 6'h00); idle_px();
    send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h03, 1'b1, 6'h03); idle_px();

    // Blanking, then hold with pix_en low
    send_px(1'b0, 6'h00, 6'h3F, 6'h00, 6'h00, 1'b1, 6'h00); idle_px();
    send_px(1'b1, 6'h00, 6'h00, 6'h0C, 6'h00, 1'b1, 6'h0C); idle_px();
    repeat (10) @(posedge clk);
    #1;
    check("hold", int'(content), 'h0C);

    // Flash sequence
    pulse_vsync();
    hit();
    check("flash_start", int'(flashing), 1);
    for (int f = 0; f < 8; f++) begin
      if (f > 0) pulse_vsync();
      send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h03, 1'b1, flash_tbl[f]); idle_px();
    end
    check("flash_frame8", int'(flashing), 1);
    pulse_vsync();
    check("flash_end", int'(flashing), 0);
    send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h03, 1'b1, 6'h03); idle_px();

    // Retrigger after 5 frames
    hit();
    repeat (5) pulse_vsync();
    check("retrig_pre", int'(flashing), 1);
    hit();
    send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h03, 1'b1, 6'h3F); idle_px();
    repeat (2) pulse_vsync();
    send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h03, 1'b1, 6'h03); idle_px();
    repeat (5) pulse_vsync();
    check("retrig_f7", int'(flashing), 1);
    pulse_vsync();
    check("retrig_end", int'(flashing), 0);

    // hit_pulse coincident with vsync_start
    hit();
    repeat (3) pulse_vsync();
    send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h03, 1'b1, 6'h03); idle_px();
    hit_pulse = 1'b1; vsync_start = 1'b1;
    @(posedge clk); #1;
    hit_pulse = 1'b0; vsync_start = 1'b0;
    send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h03, 1'b1, 6'h3F); idle_px();
    pulse_vsync();
    send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h03, 1'b1, 6'h3F); idle_px();
    repeat (6) pulse_vsync();
    check("simul_f7", int'(flashing), 1);
    pulse_vsync();
    check("simul_end", int'(flashing), 0);

    // Asynchronous reset in FLASH_OFF
    hit();
    repeat (2) pulse_vsync();
    send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h03, 1'b1, 6'h03);
    send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h03, 1'b0, 6'h00);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_content", int'(content), 0);
    check("async_rst_flashing", int'(flashing), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_flashing", int'(flashing), 0);
    send_px(1'b1, 6'h00, 6'h00, 6'h00, 6'h03, 1'b1, 6'h03); idle_px();

    // Collision flag
    pulse_vsync();
    check("coll_clear0", int'(collision), 0);
    send_px(1'b0, 6'h00, 6'h00, 6'h0C, 6'h03, 1'b1, 6'h00); idle_px();
    check("coll_blank", int'(collision), 0);
    send_px(1'b1, 6'h00, 6'h00, 6'h0C, 6'h03, 1'b1, 6'h0C); idle_px();
    check("coll_set", int'(collision), COLL_SET);
    repeat (5) @(posedge clk);
    #1;
    check("coll_held", int'(collision), COLL_SET);
    pulse_vsync();
    check("coll_vsync_clr", int'(collision), 0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
